// File: rtl/axi_master_arbiter.sv
// ============================================================================
// Module   : axi_master_arbiter
// Brief    : Round-robin, burst-granular sharing of one AXI memory port among
//            NUM_MASTERS requesters; read and write channels arbitrate apart.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef AXI_DATA_WIDTH
`define AXI_DATA_WIDTH 64
`endif

module axi_master_arbiter #(
  parameter int NUM_MASTERS    = 2,
  parameter int AXI_DATA_WIDTH = `AXI_DATA_WIDTH,
  parameter int ADDR_WIDTH     = 32
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [NUM_MASTERS-1:0]               m_awvalid,
  output logic [NUM_MASTERS-1:0]               m_awready,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]    m_awaddr,
  input  logic [NUM_MASTERS*8-1:0]             m_awlen,
  input  logic [NUM_MASTERS-1:0]               m_wvalid,
  output logic [NUM_MASTERS-1:0]               m_wready,
  input  logic [NUM_MASTERS*AXI_DATA_WIDTH-1:0] m_wdata,
  input  logic [NUM_MASTERS-1:0]               m_wlast,
  output logic [NUM_MASTERS-1:0]               m_bvalid,
  input  logic [NUM_MASTERS-1:0]               m_bready,
  input  logic [NUM_MASTERS-1:0]               m_arvalid,
  output logic [NUM_MASTERS-1:0]               m_arready,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]    m_araddr,
  input  logic [NUM_MASTERS*8-1:0]             m_arlen,
  output logic [NUM_MASTERS-1:0]               m_rvalid,
  input  logic [NUM_MASTERS-1:0]               m_rready,
  output logic [AXI_DATA_WIDTH-1:0]            m_rdata,
  output logic                                 s_awvalid,
  input  logic                                 s_awready,
  output logic [ADDR_WIDTH-1:0]                s_awaddr,
  output logic [7:0]                           s_awlen,
  output logic                                 s_wvalid,
  input  logic                                 s_wready,
  output logic [AXI_DATA_WIDTH-1:0]            s_wdata,
  output logic                                 s_wlast,
  input  logic                                 s_bvalid,
  output logic                                 s_bready,
  output logic                                 s_arvalid,
  input  logic                                 s_arready,
  output logic [ADDR_WIDTH-1:0]                s_araddr,
  output logic [7:0]                           s_arlen,
  input  logic                                 s_rvalid,
  output logic                                 s_rready,
  input  logic [AXI_DATA_WIDTH-1:0]            s_rdata
);

  localparam int c_GW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam logic [c_GW-1:0] c_LAST_RST = c_GW'(NUM_MASTERS - 1);

  localparam logic [1:0] c_R_IDLE = 2'd0;
  localparam logic [1:0] c_R_ADDR = 2'd1;
  localparam logic [1:0] c_R_DATA = 2'd2;

  localparam logic [1:0] c_W_IDLE = 2'd0;
  localparam logic [1:0] c_W_ADDR = 2'd1;
  localparam logic [1:0] c_W_DATA = 2'd2;
  localparam logic [1:0] c_W_RESP = 2'd3;

  // First requester at or after last+1, wrapping; keeps last if none request.
  function automatic logic [c_GW-1:0] f_rr_pick(input logic [NUM_MASTERS-1:0] req,
                                                input logic [c_GW-1:0] last);
    logic [c_GW-1:0] pick;
    logic [c_GW-1:0] idx;
    logic            found;
    pick  = last;
    found = 1'b0;
    for (int k = 1; k <= NUM_MASTERS; k++) begin
      idx = c_GW'((int'(last) + k) % NUM_MASTERS);
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
    return pick;
  endfunction

  logic [ADDR_WIDTH-1:0]     w_araddr [NUM_MASTERS];
  logic [ADDR_WIDTH-1:0]     w_awaddr [NUM_MASTERS];
  logic [7:0]                w_arlen  [NUM_MASTERS];
  logic [7:0]                w_awlen  [NUM_MASTERS];
  logic [AXI_DATA_WIDTH-1:0] w_wdata  [NUM_MASTERS];

  generate
    for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_unpack
      assign w_araddr[i] = m_araddr[i*ADDR_WIDTH +: ADDR_WIDTH];
      assign w_awaddr[i] = m_awaddr[i*ADDR_WIDTH +: ADDR_WIDTH];
      assign w_arlen[i]  = m_arlen[i*8 +: 8];
      assign w_awlen[i]  = m_awlen[i*8 +: 8];
      assign w_wdata[i]  = m_wdata[i*AXI_DATA_WIDTH +: AXI_DATA_WIDTH];
    end
  endgenerate

  // ---------------------------------------------------------------- read path
  logic [1:0]      r_rd_state;
  logic [1:0]      w_rd_state_nxt;
  logic [c_GW-1:0] r_rd_grant;
  logic [c_GW-1:0] r_rd_last;
  logic [7:0]      r_rd_cnt;
  logic            w_ar_hs;
  logic            w_r_beat;

  assign w_ar_hs  = s_arvalid && s_arready;
  assign w_r_beat = s_rvalid && s_rready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_state <= c_R_IDLE;
      r_rd_grant <= '0;
      r_rd_last  <= c_LAST_RST;
      r_rd_cnt   <= 8'd0;
    end else begin
      r_rd_state <= w_rd_state_nxt;
      case (r_rd_state)
        c_R_IDLE: if (|m_arvalid) r_rd_grant <= f_rr_pick(m_arvalid, r_rd_last);
        c_R_ADDR: if (w_ar_hs) r_rd_cnt <= s_arlen;
        c_R_DATA: begin
          if (w_r_beat) begin
            r_rd_cnt <= r_rd_cnt - 8'd1;
            if (r_rd_cnt == 8'd0) r_rd_last <= r_rd_grant;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_rd_state_nxt = r_rd_state;
    case (r_rd_state)
      c_R_IDLE: if (|m_arvalid) w_rd_state_nxt = c_R_ADDR;
      c_R_ADDR: if (w_ar_hs) w_rd_state_nxt = c_R_DATA;
      c_R_DATA: if (w_r_beat && (r_rd_cnt == 8'd0)) w_rd_state_nxt = c_R_IDLE;
      default:  w_rd_state_nxt = c_R_IDLE;
    endcase
  end

  always_comb begin
    s_arvalid = 1'b0;
    m_arready = '0;
    s_rready  = 1'b0;
    m_rvalid  = '0;
    s_araddr  = w_araddr[r_rd_grant];
    s_arlen   = w_arlen[r_rd_grant];
    m_rdata   = s_rdata;
    case (r_rd_state)
      c_R_ADDR: begin
        s_arvalid             = m_arvalid[r_rd_grant];
        m_arready[r_rd_grant] = s_arready;
      end
      c_R_DATA: begin
        s_rready             = m_rready[r_rd_grant];
        m_rvalid[r_rd_grant] = s_rvalid;
      end
      default: ;
    endcase
  end

  // --------------------------------------------------------------- write path
  logic [1:0]      r_wr_state;
  logic [1:0]      w_wr_state_nxt;
  logic [c_GW-1:0] r_wr_grant;
  logic [c_GW-1:0] r_wr_last;
  logic [7:0]      r_wr_cnt;
  logic            w_aw_hs;
  logic            w_w_beat;
  logic            w_b_hs;

  assign w_aw_hs  = s_awvalid && s_awready;
  assign w_w_beat = s_wvalid && s_wready;
  assign w_b_hs   = s_bvalid && s_bready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_state <= c_W_IDLE;
      r_wr_grant <= '0;
      r_wr_last  <= c_LAST_RST;
      r_wr_cnt   <= 8'd0;
    end else begin
      r_wr_state <= w_wr_state_nxt;
      case (r_wr_state)
        c_W_IDLE: if (|m_awvalid) r_wr_grant <= f_rr_pick(m_awvalid, r_wr_last);
        c_W_ADDR: if (w_aw_hs) r_wr_cnt <= s_awlen;
        c_W_DATA: if (w_w_beat) r_wr_cnt <= r_wr_cnt - 8'd1;
        c_W_RESP: if (w_b_hs) r_wr_last <= r_wr_grant;
        default: ;
      endcase
    end
  end

  always_comb begin
    w_wr_state_nxt = r_wr_state;
    case (r_wr_state)
      c_W_IDLE: if (|m_awvalid) w_wr_state_nxt = c_W_ADDR;
      c_W_ADDR: if (w_aw_hs) w_wr_state_nxt = c_W_DATA;
      c_W_DATA: if (w_w_beat && (r_wr_cnt == 8'd0)) w_wr_state_nxt = c_W_RESP;
      c_W_RESP: if (w_b_hs) w_wr_state_nxt = c_W_IDLE;
      default:  w_wr_state_nxt = c_W_IDLE;
    endcase
  end

  // The wlast from the requester is forwarded untouched; the beat counter alone
  // decides when the burst ends.
  always_comb begin
    s_awvalid = 1'b0;
    m_awready = '0;
    s_wvalid  = 1'b0;
    m_wready  = '0;
    s_bready  = 1'b0;
    m_bvalid  = '0;
    s_awaddr  = w_awaddr[r_wr_grant];
    s_awlen   = w_awlen[r_wr_grant];
    s_wdata   = w_wdata[r_wr_grant];
    s_wlast   = m_wlast[r_wr_grant];
    case (r_wr_state)
      c_W_ADDR: begin
        s_awvalid             = m_awvalid[r_wr_grant];
        m_awready[r_wr_grant] = s_awready;
      end
      c_W_DATA: begin
        s_wvalid             = m_wvalid[r_wr_grant];
        m_wready[r_wr_grant] = s_wready;
      end
      c_W_RESP: begin
        m_bvalid[r_wr_grant] = s_bvalid;
        s_bready             = m_bready[r_wr_grant];
      end
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_axi_master_arbiter.sv
// ============================================================================
// Module   : tb_axi_master_arbiter
// Brief    : Directed bench for axi_master_arbiter with two requesters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_axi_master_arbiter;

  localparam int c_N  = 2;
  localparam int c_DW = 32;
  localparam int c_AW = 32;

  localparam logic [31:0] c_A0 = 32'h0000_1000;
  localparam logic [31:0] c_A1 = 32'h0000_2000;
  localparam logic [31:0] c_B0 = 32'h0000_3000;
  localparam logic [31:0] c_B1 = 32'h0000_4000;

  logic                clk = 1'b0;
  logic                reset;
  logic [c_N-1:0]      m_awvalid, m_awready, m_wvalid, m_wready, m_wlast;
  logic [c_N-1:0]      m_bvalid, m_bready, m_arvalid, m_arready, m_rvalid, m_rready;
  logic [c_N*c_AW-1:0] m_awaddr, m_araddr;
  logic [c_N*8-1:0]    m_awlen, m_arlen;
  logic [c_N*c_DW-1:0] m_wdata;
  logic [c_DW-1:0]     m_rdata;
  logic                s_awvalid, s_awready, s_wvalid, s_wready, s_wlast;
  logic                s_bvalid, s_bready, s_arvalid, s_arready, s_rvalid, s_rready;
  logic [c_AW-1:0]     s_awaddr, s_araddr;
  logic [7:0]          s_awlen, s_arlen;
  logic [c_DW-1:0]     s_wdata, s_rdata;

  int n_chk = 0;
  int n_err = 0;
  int n_beats;

  always #5 clk = ~clk;

  axi_master_arbiter #(
    .NUM_MASTERS(c_N), .AXI_DATA_WIDTH(c_DW), .ADDR_WIDTH(c_AW)
  ) dut (
    .clk(clk), .reset(reset),
    .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr), .m_awlen(m_awlen),
    .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wlast(m_wlast),
    .m_bvalid(m_bvalid), .m_bready(m_bready),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr), .m_arlen(m_arlen),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata),
    .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr), .s_awlen(s_awlen),
    .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wlast(s_wlast),
    .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr), .s_arlen(s_arlen),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    m_awvalid = '0; m_wvalid = '0; m_wlast = '0; m_bready = '0;
    m_arvalid = '0; m_rready = '0; m_wdata = '0;
    m_awaddr = {c_B1, c_B0}; m_araddr = {c_A1, c_A0};
    m_awlen = '0; m_arlen = '0;
    s_awready = 1'b0; s_wready = 1'b0; s_bvalid = 1'b0;
    s_arready = 1'b0; s_rvalid = 1'b0; s_rdata = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    // ---- reset state: every handshake output low even with slave inputs high
    do_reset();
    s_arready = 1'b1; s_awready = 1'b1; s_wready = 1'b1; s_rvalid = 1'b1; s_bvalid = 1'b1;
    m_rready = 2'b11; m_bready = 2'b11; m_wvalid = 2'b11;
    #1;
    chk("rst_ctrl_zero", 64'({s_arvalid, s_awvalid, s_wvalid, s_rready, s_bready,
                             m_arready, m_awready, m_wready, m_rvalid, m_bvalid}), 64'd0);
    chk("rst_araddr_slice0", 64'(s_araddr), 64'(c_A0));
    chk("rst_awaddr_slice0", 64'(s_awaddr), 64'(c_B0));
    clear_inputs();

    // ---- requester 0 reads 4 beats
    m_arlen = {8'd0, 8'd3}; m_rready = 2'b01; m_arvalid = 2'b01;
    #1;
    chk("t1_idle_no_arvalid", 64'(s_arvalid), 64'd0);
    step(); #1;
    chk("t1_arvalid", 64'(s_arvalid), 64'd1);
    chk("t1_araddr", 64'(s_araddr), 64'(c_A0));
    chk("t1_arlen", 64'(s_arlen), 64'd3);
    chk("t1_arready_wait", 64'(m_arready), 64'd0);
    s_arready = 1'b1; #1;
    chk("t1_arready", 64'(m_arready), 64'b01);
    step();
    m_arvalid = '0; s_arready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      s_rvalid = 1'b1; s_rdata = 32'hA0 + 32'(i); #1;
      chk("t1_rvalid", 64'(m_rvalid), 64'b01);
      chk("t1_rdata", 64'(m_rdata), 64'(32'hA0 + 32'(i)));
      step();
    end
    #1;
    chk("t1_done_rvalid", 64'(m_rvalid), 64'd0);
    chk("t1_done_rready", 64'(s_rready), 64'd0);
    s_rvalid = 1'b0;

    // ---- both requesters read continuously with single-beat bursts
    do_reset();
    m_arvalid = 2'b11; s_arready = 1'b1; s_rvalid = 1'b1; s_rdata = 32'h5A; m_rready = 2'b11;
    for (int b = 0; b < 4; b++) begin
      step(); #1;
      chk("t2_araddr", 64'(s_araddr), (b % 2 == 1) ? 64'(c_A1) : 64'(c_A0));
      chk("t2_arready", 64'(m_arready), (b % 2 == 1) ? 64'b10 : 64'b01);
      step(); #1;
      chk("t2_rvalid", 64'(m_rvalid), (b % 2 == 1) ? 64'b10 : 64'b01);
      step();
    end
    m_arvalid = '0; s_rvalid = 1'b0; s_arready = 1'b0;

    // ---- requester 1 writes 2 beats with toggling wready; requester 0 waits
    m_awvalid = 2'b10; m_awlen = {8'd1, 8'd0}; s_awready = 1'b1; #1;
    chk("t3_idle_no_awvalid", 64'(s_awvalid), 64'd0);
    step(); #1;
    chk("t3_awvalid", 64'(s_awvalid), 64'd1);
    chk("t3_awaddr", 64'(s_awaddr), 64'(c_B1));
    chk("t3_awlen", 64'(s_awlen), 64'd1);
    chk("t3_awready", 64'(m_awready), 64'b10);
    step();
    m_awvalid = 2'b01; m_wvalid = 2'b10; m_wdata = {32'hD100, 32'h0}; m_wlast = 2'b00;
    s_wready = 1'b1; #1;
    chk("t3_wvalid", 64'(s_wvalid), 64'd1);
    chk("t3_wdata0", 64'(s_wdata), 64'h D100);
    chk("t3_wready", 64'(m_wready), 64'b10);
    chk("t3_no_aw_in_data", 64'({s_awvalid, m_awready}), 64'd0);
    step();
    s_wready = 1'b0; m_wdata = {32'hD101, 32'h0}; m_wlast = 2'b10; #1;
    chk("t3_wlast", 64'(s_wlast), 64'd1);
    chk("t3_wready_low", 64'(m_wready), 64'd0);
    step();
    s_wready = 1'b1; #1;
    chk("t3_wdata1", 64'(s_wdata), 64'h D101);
    step();
    m_bready = 2'b10; #1;
    chk("t3_resp_no_wvalid", 64'(s_wvalid), 64'd0);
    chk("t3_resp_no_wready", 64'(m_wready), 64'd0);
    chk("t3_bready", 64'(s_bready), 64'd1);
    chk("t3_bvalid_low", 64'(m_bvalid), 64'd0);
    step();
    s_bvalid = 1'b1; #1;
    chk("t3_bvalid", 64'(m_bvalid), 64'b10);
    chk("t3_aw_blocked", 64'(s_awvalid), 64'd0);
    step();
    s_bvalid = 1'b0; m_wvalid = '0; #1;
    chk("t3_idle_after_b", 64'({s_awvalid, m_bvalid}), 64'd0);
    step(); #1;
    chk("t3_grant0_awaddr", 64'(s_awaddr), 64'(c_B0));
    chk("t3_grant0_awready", 64'(m_awready), 64'b01);

    // ---- concurrent read (req 0) and write (req 1)
    do_reset();
    m_arvalid = 2'b01; m_awvalid = 2'b10; #1;
    chk("t4_idle", 64'({s_arvalid, s_awvalid}), 64'd0);
    step(); #1;
    chk("t4_both_valid", 64'({s_arvalid, s_awvalid}), 64'b11);
    chk("t4_addrs", 64'({s_araddr, s_awaddr}), {c_A0, c_B1});
    s_arready = 1'b1; s_awready = 1'b1; #1;
    chk("t4_readies", 64'({m_arready, m_awready}), 64'b0110);
    step();
    m_arvalid = '0; m_awvalid = '0;
    s_rvalid = 1'b1; s_rdata = 32'h55; m_rready = 2'b01;
    m_wvalid = 2'b10; m_wdata = {32'h77, 32'h0}; m_wlast = 2'b10; s_wready = 1'b1; #1;
    chk("t4_rvalid", 64'(m_rvalid), 64'b01);
    chk("t4_rdata", 64'(m_rdata), 64'h55);
    chk("t4_wpath", 64'({s_wvalid, s_wlast, m_wready, s_rready}), 64'b11101);
    chk("t4_wdata", 64'(s_wdata), 64'h77);
    step();
    s_rvalid = 1'b0; m_wvalid = '0; s_bvalid = 1'b1; m_bready = 2'b10; #1;
    chk("t4_resp", 64'({m_rvalid, m_bvalid, s_bready}), 64'b00101);
    step();
    s_bvalid = 1'b0; #1;
    chk("t4_done", 64'({m_bvalid, s_bready}), 64'd0);

    // ---- reset in the middle of a 4-beat read
    clear_inputs();
    m_arvalid = 2'b01; m_arlen = {8'd0, 8'd3}; s_arready = 1'b1;
    step();
    step();
    m_arvalid = '0; s_rvalid = 1'b1; m_rready = 2'b11; #1;
    chk("t5_beat1", 64'(m_rvalid), 64'b01);
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0; m_arvalid = 2'b10; #1;
    chk("t5_after_rst", 64'({m_rvalid, s_rready, s_arvalid, m_arready}), 64'd0);
    step(); #1;
    chk("t5_grant1_addr", 64'(s_araddr), 64'(c_A1));
    chk("t5_grant1_ready", 64'(m_arready), 64'b10);

    // ---- 256-beat read
    do_reset();
    m_arvalid = 2'b01; m_arlen = {8'd0, 8'd255}; s_arready = 1'b1;
    step(); #1;
    chk("t6_arlen", 64'(s_arlen), 64'd255);
    step();
    m_arvalid = '0; s_rvalid = 1'b1; m_rready = 2'b01;
    n_beats = 0;
    for (int i = 0; i < 256; i++) begin
      #1;
      if (m_rvalid == 2'b01 && s_rready) n_beats++;
      step();
    end
    #1;
    chk("t6_beats", 64'(n_beats), 64'd256);
    chk("t6_exit", 64'({m_rvalid, s_rready}), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
